des_block_loader: RTL and testbench
===================================

DES_BLOCK_LOADER -- requirements
Module: des_block_loader

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 places the first accepted byte in out_block[63:56]; 0 places it in out_block[7:0].
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_byte carries a valid byte.
REQ-005 SHALL have port in_byte  input  8  byte stream of a 64-bit DES block or key.
REQ-006 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-007 SHALL have port abort  input  1  synchronous discard of the partially assembled block.
REQ-008 SHALL have port out_valid  output  1  out_block holds a complete block.
REQ-009 SHALL have port out_block  output  64  assembled block, feeding the 64-bit block register.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_block this cycle.
REQ-011 SHALL have port out_parity_err  output  1  parity flag qualified by out_valid.
REQ-012 SHALL have port fill  output  4  bytes held in the partial block, 0..7.

Function
REQ-013 SHALL accept a byte on a rising edge where in_valid=1 and in_ready=1; no other byte is accepted.
REQ-014 SHALL, for MSB_FIRST=1, shift each accepted byte in as {partial[55:0], in_byte}; for MSB_FIRST=0, as {in_byte, partial[63:8]}.
REQ-015 SHALL increment the byte counter on each accept; the 8th accept wraps it from 7 to 0.
REQ-016 SHALL, on the 8th accept, load out_block with the completed block on that same edge and set out_valid=1, so out_valid is visible the cycle after the 8th byte.
REQ-017 SHALL clear out_valid on an edge where out_valid=1, out_ready=1, and no 8th byte is accepted.
REQ-018 SHALL drive in_ready = !abort && !(count==7 && out_valid && !out_ready), combinationally.
REQ-019 SHALL, when the 8th byte is accepted on the same edge as an output handshake, load the new block and keep out_valid=1 (zero-bubble throughput: one block per 8 cycles).
REQ-020 SHALL hold out_block and out_parity_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on abort=1, clear the counter and the partial block; it SHALL NOT disturb out_valid, out_block or out_parity_err.
REQ-022 SHALL accept out_ready in the abort cycle as a normal output handshake.
REQ-023 SHALL drive fill with the current counter value.
REQ-024 SHALL ignore in_byte whenever in_valid=0.

Reset
REQ-025 SHALL, while rst=0, force counter=0, partial=0, out_block=0, out_valid=0 and out_parity_err=0, independent of clk.
REQ-026 SHALL present in_ready=1 in the first cycle after rst deasserts (absent abort).
REQ-027 SHALL discard a partial block on reset mid-fill; the next accepted byte is byte 0.

Configuration
REQ-028 SHALL, with DES_PARITY_CHECK_EN defined, check each accepted byte for DES odd parity (XOR of 8 bits = 1).
REQ-029 SHALL, with DES_PARITY_CHECK_EN defined, keep a per-block sticky error bit, cleared at block start and on abort, and copy it into out_parity_err with out_block.
REQ-030 SHALL, without DES_PARITY_CHECK_EN, tie out_parity_err to 0 and synthesize no parity logic; the port list is identical in both builds.

Verification
REQ-031 SHALL cover: MSB_FIRST=1, bytes 13 34 57 79 9B BC DF F1 on consecutive cycles with out_ready=1 -> out_block=0x133457799BBCDFF1, out_valid high one cycle, out_parity_err=0.
REQ-032 SHALL cover: with the macro defined, bytes DE AD BE EF DE AD BE EF -> out_block=0xDEADBEEFDEADBEEF and out_parity_err=1; without the macro -> out_parity_err=0.
REQ-033 SHALL cover: out_ready=0 after block 0x0123456789ABCDEF, then 7 more bytes of 0xAA -> fill=7, in_ready=0; raise out_ready -> 8th 0xAA accepted on the handshake edge, next out_block=0xAAAAAAAAAAAAAAAA, out_valid stays 1.
REQ-034 SHALL cover: 3 bytes 11 22 33, abort for one cycle, then 8 bytes of FF -> out_block=0xFFFFFFFFFFFFFFFF, fill=0 after abort, in_ready=0 during abort.
REQ-035 SHALL cover: rst=0 asserted between clk edges mid-fill (fill=5) -> out_valid, fill and out_block read 0 immediately; after release, 8 bytes 01..08 -> out_block=0x0102030405060708.
REQ-036 SHALL cover: MSB_FIRST=0, bytes 01..08 -> out_block=0x0807060504030201.

Source files
------------

// File: rtl/des_block_loader.sv
// Packs a byte stream into 64-bit DES blocks/keys with a one-block output register.
// Optional macro DES_PARITY_CHECK_EN adds per-block DES odd-parity checking.
module des_block_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        abort,
  output logic        out_valid,
  output logic [63:0] out_block,
  input  logic        out_ready,
  output logic        out_parity_err,
  output logic [3:0]  fill
);

  logic [2:0]  count_q, count_d;
  logic [63:0] partial_q, partial_d;
  logic [63:0] block_q, block_d;
  logic        valid_q, valid_d;
  logic        accept, last;
  logic [63:0] shifted;

  // Refuse the 8th byte only when the output register cannot be freed this cycle.
  assign in_ready = !abort && !((count_q == 3'd7) && valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (count_q == 3'd7);
  assign shifted  = MSB_FIRST ? {partial_q[55:0], in_byte} : {in_byte, partial_q[63:8]};

  always_comb begin
    count_d   = count_q;
    partial_d = partial_q;
    block_d   = block_q;
    valid_d   = valid_q;
    if (abort) begin
      count_d   = 3'd0;
      partial_d = '0;
    end else if (accept) begin
      count_d   = count_q + 3'd1;
      partial_d = last ? '0 : shifted;
    end
    // A freshly completed block wins over the handshake so throughput has no bubble.
    if (last) begin
      block_d = shifted;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 3'd0;
      partial_q <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      partial_q <= partial_d;
      block_q   <= block_d;
      valid_q   <= valid_d;
    end
  end

`ifdef DES_PARITY_CHECK_EN
  logic sticky_q, sticky_d;
  logic perr_q, perr_d;
  logic byte_err, sticky_upd;

  // DES key bytes carry odd parity; an even-weight byte is an error.
  assign byte_err   = ~(^in_byte);
  assign sticky_upd = ((count_q == 3'd0) ? 1'b0 : sticky_q) | byte_err;

  always_comb begin
    sticky_d = sticky_q;
    perr_d   = perr_q;
    if (abort) begin
      sticky_d = 1'b0;
    end else if (accept) begin
      sticky_d = last ? 1'b0 : sticky_upd;
    end
    if (last) begin
      perr_d = sticky_upd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      perr_q   <= perr_d;
    end
  end

  assign out_parity_err = perr_q;
`else
  assign out_parity_err = 1'b0;
`endif

  assign out_valid = valid_q;
  assign out_block = block_q;
  assign fill      = {1'b0, count_q};

endmodule

// File: tb/tb_des_block_loader.sv
// Scoreboard bench for des_block_loader: MSB-first and LSB-first instances share one stimulus stream.
module tb_des_block_loader;

`ifdef DES_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_parity_err;
  logic [63:0] out_block;
  logic [3:0]  fill;
  logic        in_ready_l, out_valid_l, out_parity_err_l;
  logic [63:0] out_block_l;
  logic [3:0]  fill_l;

  always #5 clk = ~clk;

  des_block_loader #(.MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .abort(abort), .out_valid(out_valid), .out_block(out_block), .out_ready(out_ready),
    .out_parity_err(out_parity_err), .fill(fill)
  );

  des_block_loader #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_l),
    .abort(abort), .out_valid(out_valid_l), .out_block(out_block_l), .out_ready(out_ready),
    .out_parity_err(out_parity_err_l), .fill(fill_l)
  );

  typedef struct {
    logic [63:0] m;
    logic [63:0] l;
    logic        p;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  bq[$];
  exp_t        sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a block is the 8 collected bytes placed by weight; parity error if any byte has even weight.
  function automatic exp_t make_exp();
    exp_t e;
    e.m = '0;
    e.l = '0;
    e.p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.m = e.m | (64'(bq[i]) << (8 * (7 - i)));
      e.l = e.l | (64'(bq[i]) << (8 * i));
      if (($countones(bq[i]) % 2) == 0) e.p = PAR_EN;
    end
    return e;
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input bit ab, input bit ordy);
    bit er;
    @(negedge clk);
    in_valid = v; in_byte = b; abort = ab; out_ready = ordy;
    #1;
    er = !ab && !((bq.size() == 7) && (sb.size() != 0) && !ordy);
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("fill", 64'(fill), 64'(bq.size()));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("lsb_in_ready", 64'(in_ready_l), 64'(er));
    chk("lsb_fill", 64'(fill_l), 64'(bq.size()));
    chk("lsb_out_valid", 64'(out_valid_l), 64'(sb.size() != 0));
    if (ab) begin
      bq.delete();
    end else if (v && er) begin
      bq.push_back(b);
      if (bq.size() == 8) begin
        sb.push_back(make_exp());
        bq.delete();
      end
    end
  endtask

  task automatic peek(input string name, input logic [63:0] exp_m, input bit exp_p);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_block"}, out_block, exp_m);
    chk({name, "_perr"}, 64'(out_parity_err), 64'(exp_p));
  endtask

  task automatic reset_mid(input int exp_fill);
    @(negedge clk);
    #2;
    chk("pre_reset_fill", 64'(fill), 64'(exp_fill));
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    chk("rst_perr", 64'(out_parity_err), 64'd0);
    bq.delete();
    sb.delete();
    in_valid = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares the block each time the consumer takes one, and checks hold during stalls.
  logic        stall_prev = 1'b0;
  logic [63:0] prev_blk = '0;
  logic        prev_perr = 1'b0;
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (rst) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_block", out_block, prev_blk);
        chk("hold_perr", 64'(out_parity_err), 64'(prev_perr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_block: got %h expected none", out_block);
        end else begin
          e = sb.pop_front();
          chk("msb_block", out_block, e.m);
          chk("lsb_block", out_block_l, e.l);
          chk("msb_perr", 64'(out_parity_err), 64'(e.p));
          chk("lsb_perr", 64'(out_parity_err_l), 64'(e.p));
        end
      end
    end
    stall_prev = rst && out_valid && !out_ready;
    prev_blk   = out_block;
    prev_perr  = out_parity_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v31[8];
    logic [7:0] v33[8];
    v31 = '{8'h13, 8'h34, 8'h57, 8'h79, 8'h9B, 8'hBC, 8'hDF, 8'hF1};
    v33 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    #3;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_block", out_block, 64'd0);
    chk("reset_fill", 64'(fill), 64'd0);
    chk("reset_perr", 64'(out_parity_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b1, v31[i], 1'b0, 1'b1);
    peek("r31", 64'h133457799BBCDFF1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, (i % 4 == 0) ? 8'hDE : (i % 4 == 1) ? 8'hAD :
                                          (i % 4 == 2) ? 8'hBE : 8'hEF, 1'b0, 1'b1);
    peek("r32", 64'hDEADBEEFDEADBEEF, PAR_EN);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, v33[i], 1'b0, 1'b0);
    peek("r33a", 64'h0123456789ABCDEF, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("r33_fill", 64'(fill), 64'd7);
    chk("r33_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    peek("r33b", 64'hAAAAAAAAAAAAAAAA, PAR_EN);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    chk("r34_in_ready_abort", 64'(in_ready), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("r34_fill", 64'(fill), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'hFF, 1'b0, 1'b1);
    peek("r34", 64'hFFFFFFFFFFFFFFFF, PAR_EN);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    reset_mid(5);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    peek("r35", 64'h0102030405060708, PAR_EN);
    chk("r36_lsb_block", out_block_l, 64'h0807060504030201);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 32) == 0, ($urandom % 3) != 0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
